// File: rtl/buffered_spi_pkg.sv
// Shared constants for the buffered SPI responder.
package buffered_spi_pkg;

    localparam int unsigned WORD_BITS_DEF = 16;
    localparam logic [15:0] FILL_WORD_DEF = 16'hFFFF;
    localparam int unsigned SYNC_STAGES   = 2;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

endpackage

// File: rtl/buffered_spi_slave_sync_fifo.sv
// Single-clock FIFO with occupancy counter; pop takes priority so a full
// FIFO can accept a push in the same cycle as a pop.
module sync_fifo
    import buffered_spi_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/buffered_spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins, deserialises words into
// an RX FIFO and serialises words from a TX FIFO onto miso.
module buffered_spi_slave
    import buffered_spi_pkg::*;
#(
    parameter int unsigned          WORD_BITS  = WORD_BITS_DEF,
    parameter int unsigned          FIFO_DEPTH = 16,
    parameter logic [WORD_BITS-1:0] FILL_WORD  = FILL_WORD_DEF
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          buffered_spi_clk,
    input  logic                          buffered_spi_cs,
    input  logic                          buffered_spi_mosi,
    output logic                          buffered_spi_miso,
    output logic                          buffered_spi_sync,
    output logic [WORD_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [WORD_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          overrun,
    output logic                          underrun,
    input  logic                          clear_flags
);

    localparam int unsigned CW = $clog2(WORD_BITS);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [1:0]             state;
    logic [CW-1:0]          bit_cnt;
    logic                   word_done;
    logic [WORD_BITS-2:0]   rx_shift;
    logic [WORD_BITS-2:0]   tx_shift;
    logic                   alive;

    logic [WORD_BITS-1:0]   rx_word;
    logic                   rx_push, rx_full, rx_empty;
    logic [WORD_BITS-1:0]   tx_head, load_word;
    logic                   tx_push, tx_pop, tx_full, tx_empty;
    logic                   overrun_set, underrun_set;

    // Two-stage synchronisers plus edge-detect history for the SPI pins
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], buffered_spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], buffered_spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], buffered_spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    assign rx_word      = {rx_shift, mosi_s};
    assign rx_push      = (state == ST_SHIFT) && !cs_rise && sclk_rise
                          && (bit_cnt == CW'(WORD_BITS-1));
    assign load_word    = tx_empty ? FILL_WORD : tx_head;
    assign tx_pop       = (state == ST_LOAD) && !cs_rise && !tx_empty;
    assign underrun_set = (state == ST_LOAD) && !cs_rise && tx_empty;
    assign overrun_set  = rx_push && rx_full && !(rx_ready && !rx_empty);
    assign tx_push      = tx_valid & tx_ready;
    assign tx_ready     = alive & ~tx_full;
    assign rx_valid     = ~rx_empty;

    // Responder FSM; tx_shift holds only the bits still queued behind miso
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state             <= ST_IDLE;
            bit_cnt           <= '0;
            word_done         <= 1'b0;
            rx_shift          <= '0;
            tx_shift          <= '0;
            buffered_spi_miso <= 1'b0;
        end else if (cs_rise) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (cs_fall) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    tx_shift          <= load_word[WORD_BITS-2:0];
                    buffered_spi_miso <= load_word[WORD_BITS-1];
                    state             <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_word[WORD_BITS-2:0];
                        if (bit_cnt == CW'(WORD_BITS-1)) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (word_done) begin
                            word_done <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            buffered_spi_miso <= tx_shift[WORD_BITS-2];
                            tx_shift          <= {tx_shift[WORD_BITS-3:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= (overrun & ~clear_flags) | overrun_set;
            underrun <= (underrun & ~clear_flags) | underrun_set;
        end
    end

    // Flow-control outputs come up one cycle after reset release
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            alive             <= 1'b0;
            buffered_spi_sync <= 1'b0;
        end else begin
            alive             <= 1'b1;
            buffered_spi_sync <= (rx_level < LW'(FIFO_DEPTH-1));
        end
    end

    sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (rx_push),
        .wdata (rx_word),
        .pop   (rx_ready),
        .rdata (rx_data),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (tx_push),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

endmodule

// File: tb/tb_buffered_spi_slave.sv
// Directed bench for buffered_spi_slave acting as an SPI master at clk/10.
module tb_buffered_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, sync_o;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [4:0]  rx_level, tx_level;
    logic        overrun, underrun;
    logic        clear_flags = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    logic        v2, v3;
    logic [15:0] popped;
    logic [15:0] mi;

    always #5 clk = ~clk;

    buffered_spi_slave #(.WORD_BITS(16), .FIFO_DEPTH(16), .FILL_WORD(16'hFFFF)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .buffered_spi_clk  (sclk),
        .buffered_spi_cs   (cs),
        .buffered_spi_mosi (mosi),
        .buffered_spi_miso (miso),
        .buffered_spi_sync (sync_o),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .rx_level          (rx_level),
        .tx_level          (tx_level),
        .overrun           (overrun),
        .underrun          (underrun),
        .clear_flags       (clear_flags)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] bw(input int i);
        return 16'hC000 | 16'(i);
    endfunction

    // Send nbits MSB-first; sample miso on each rising sclk. end_cs raises cs
    // together with the final falling sclk. pop_at_end pulses rx_ready for the
    // clock edge that pushes the last bit's word (3rd edge after the rise).
    task automatic spi_bits(input logic [15:0] w, input int nbits, input bit end_cs,
                            input bit pop_at_end, output logic [15:0] mo);
        mo = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            negs(5);
            sclk = 1'b1;
            mo[15-i] = miso;
            negs(2);
            v2 = rx_valid;
            if (pop_at_end && i == nbits-1) begin
                popped = rx_data;
                rx_ready = 1'b1;
            end
            negs(1);
            rx_ready = 1'b0;
            v3 = rx_valid;
            negs(2);
            sclk = 1'b0;
            if (end_cs && i == nbits-1) cs = 1'b1;
        end
        if (end_cs) negs(5);
    endtask

    task automatic pop_one;
        rx_ready = 1'b1;
        negs(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        negs(2);
        check("rst_miso", 32'(miso), 0);
        check("rst_sync", 32'(sync_o), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_level", 32'(rx_level), 0);
        check("rst_tx_level", 32'(tx_level), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_underrun", 32'(underrun), 0);
        rst_n = 1'b1;
        negs(1);
        check("rel_tx_ready", 32'(tx_ready), 1);
        check("rel_sync", 32'(sync_o), 1);

        // Single word with TX preloaded
        tx_data = 16'hA55A; tx_valid = 1'b1;
        negs(1);
        tx_valid = 1'b0;
        check("t1_tx_level_pre", 32'(tx_level), 1);
        cs = 1'b0;
        spi_bits(16'h1234, 16, 1'b1, 1'b0, mi);
        check("t1_miso_word", 32'(mi), 32'hA55A);
        check("t1_valid_edge2", 32'(v2), 0);
        check("t1_valid_edge3", 32'(v3), 1);
        check("t1_rx_data", 32'(rx_data), 32'h1234);
        check("t1_overrun", 32'(overrun), 0);
        check("t1_underrun", 32'(underrun), 0);
        check("t1_tx_level_post", 32'(tx_level), 0);
        pop_one();
        check("t1_rx_valid_popped", 32'(rx_valid), 0);

        // Empty TX -> fill word and underrun
        cs = 1'b0;
        spi_bits(16'h5AA5, 16, 1'b1, 1'b0, mi);
        check("t2_miso_fill", 32'(mi), 32'hFFFF);
        check("t2_underrun", 32'(underrun), 1);
        check("t2_rx_data", 32'(rx_data), 32'h5AA5);
        clear_flags = 1'b1;
        negs(1);
        clear_flags = 1'b0;
        check("t2_underrun_clr", 32'(underrun), 0);
        pop_one();

        // Burst of 17 words with cs held low and no pops
        cs = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            spi_bits(bw(i), 16, (i == 17), 1'b0, mi);
            if (i == 14) begin
                check("t3_level14", 32'(rx_level), 14);
                check("t3_sync14", 32'(sync_o), 1);
            end
            if (i == 15) begin
                check("t3_level15", 32'(rx_level), 15);
                check("t3_sync15", 32'(sync_o), 0);
            end
        end
        check("t3_level_full", 32'(rx_level), 16);
        check("t3_overrun", 32'(overrun), 1);
        clear_flags = 1'b1;
        negs(1);
        clear_flags = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 0);

        // Full RX FIFO: push and pop on the same edge
        cs = 1'b0;
        spi_bits(16'h7E81, 16, 1'b1, 1'b1, mi);
        check("t4_popped_word1", 32'(popped), 32'(bw(1)));
        check("t4_level_full", 32'(rx_level), 16);
        check("t4_no_overrun", 32'(overrun), 0);
        for (int i = 2; i <= 16; i++) begin
            check($sformatf("t4_drain_%0d", i), 32'(rx_data), 32'(bw(i)));
            pop_one();
        end
        check("t4_tail", 32'(rx_data), 32'h7E81);
        pop_one();
        check("t4_empty", 32'(rx_valid), 0);

        // Abort after 9 bits, then a clean word
        cs = 1'b0;
        spi_bits(16'h1357, 9, 1'b1, 1'b0, mi);
        check("t5_abort_level", 32'(rx_level), 0);
        cs = 1'b0;
        spi_bits(16'hBEEF, 16, 1'b1, 1'b0, mi);
        check("t5_level", 32'(rx_level), 1);
        check("t5_rx_data", 32'(rx_data), 32'hBEEF);
        pop_one();

        // Reset asserted mid-word after 7 bits
        cs = 1'b0;
        spi_bits(16'hAAAA, 7, 1'b0, 1'b0, mi);
        tx_data = 16'h4321; tx_valid = 1'b1;
        negs(1);
        tx_valid = 1'b0;
        check("t6_tx_level_pre", 32'(tx_level), 1);
        rst_n = 1'b0;
        #1;
        check("t6_miso", 32'(miso), 0);
        check("t6_sync", 32'(sync_o), 0);
        check("t6_rx_valid", 32'(rx_valid), 0);
        check("t6_tx_ready", 32'(tx_ready), 0);
        check("t6_rx_level", 32'(rx_level), 0);
        check("t6_tx_level", 32'(tx_level), 0);
        check("t6_flags", 32'({overrun, underrun}), 0);
        cs = 1'b1;
        negs(3);
        rst_n = 1'b1;
        negs(4);
        check("t6_tx_ready_up", 32'(tx_ready), 1);
        cs = 1'b0;
        spi_bits(16'h0F0F, 16, 1'b1, 1'b0, mi);
        check("t6_level", 32'(rx_level), 1);
        check("t6_rx_data", 32'(rx_data), 32'h0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
